cmd_exec: RTL and testbench

CMD_EXEC -- requirements
Module: cmd_exec

---
 rtl/tour_cmd_pkg.sv | 40 ++++
 rtl/cmd_exec_if.sv | 27 ++
 rtl/sq_timer.sv | 31 +++
 rtl/cmd_exec.sv | 166 ++++++++++++++++
 tb/tb_cmd_exec.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/tour_cmd_pkg.sv
// Shared command-word definitions for the tour command executor: opcode
// encodings, command-word field positions, FSM state encoding and the
// helper that turns a square count into a move-timer load value.
package tour_cmd_pkg;

  // Command word layout: [15:12] opcode, [11:4] heading, [3:0] squares.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int HDG_MSB = 11;
  localparam int HDG_LSB = 4;
  localparam int SQ_MSB  = 3;
  localparam int SQ_LSB  = 0;

  // Wide enough for 15 squares * 256 cycles per square.
  localparam int CNT_W = 12;

  typedef enum logic [3:0] {
    OP_CAL     = 4'h0,
    OP_MOVE    = 4'h2,
    OP_MOVE_FF = 4'h3,
    OP_TOUR    = 4'h4
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAL,
    ST_MOVE,
    ST_RESP
  } state_e;

  // Timer load for a k-square move: the counter sits at zero in the last
  // moving cycle, so the load is one less than the total cycle count.
  function automatic logic [CNT_W-1:0] move_load(input logic [3:0] squares,
                                                 input int sq_cycles);
    logic [CNT_W-1:0] total;
    total = CNT_W'(squares) * CNT_W'(sq_cycles);
    return total - CNT_W'(1);
  endfunction

endpackage

// File: rtl/cmd_exec_if.sv
// Command/response bus between the command source (master) and the
// command executor (slave).
interface cmd_exec_if;
  import tour_cmd_pkg::*;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  heading;
  logic        moving;
  logic        fanfare;
  logic        tour_go;
  logic        busy;
  logic        err;

  modport master (
    output cmd, cmd_rdy,
    input  clr_cmd_rdy, send_resp, heading, moving, fanfare, tour_go, busy, err
  );

  modport slave (
    input  cmd, cmd_rdy,
    output clr_cmd_rdy, send_resp, heading, moving, fanfare, tour_go, busy, err
  );

endinterface

// File: rtl/sq_timer.sv
// Loadable down-counter used for calibrate and move timing. It stops at
// zero rather than wrapping, so a stray enable in the last cycle is harmless.
module sq_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Counter register: load has priority over counting down.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cmd_exec.sv
// Command executor: accepts one command word from IDLE, acknowledges it,
// runs calibrate / move / tour / error handling, then pulses a response.
// CAL doubles as the generic timed-wait state: tour and unknown opcodes
// spend a single zero-length wait there before the response.
module cmd_exec
  import tour_cmd_pkg::*;
#(
  parameter int SQ_CYCLES  = 16,
  parameter int CAL_CYCLES = 8
) (
  input  logic      clk,
  input  logic      rst,
  cmd_exec_if.slave bus
);

  state_e           state_q, state_d;
  logic [7:0]       heading_q, heading_d;
  logic             ff_q, ff_d;
  logic             moving_q, moving_d;
  logic             clr_q, clr_d;
  logic             send_q, send_d;
  logic             fan_q, fan_d;
  logic             tour_q, tour_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             tmr_load;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  logic [3:0]       cmd_op;
  logic [7:0]       cmd_hdg;
  logic [3:0]       cmd_sq;

  assign cmd_op  = bus.cmd[OP_MSB:OP_LSB];
  assign cmd_hdg = bus.cmd[HDG_MSB:HDG_LSB];
  assign cmd_sq  = bus.cmd[SQ_MSB:SQ_LSB];

  sq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state, timer control and next-cycle output values.
  // NOTE: every signal written here gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    ff_d      = ff_q;
    moving_d  = 1'b0;
    clr_d     = 1'b0;
    send_d    = 1'b0;
    fan_d     = 1'b0;
    tour_d    = 1'b0;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_rdy) begin
          clr_d    = 1'b1;
          tmr_load = 1'b1;
          case (cmd_op)
            OP_CAL: begin
              state_d = ST_CAL;
              tmr_val = CNT_W'(CAL_CYCLES - 1);
            end
            OP_MOVE, OP_MOVE_FF: begin
              state_d   = ST_MOVE;
              heading_d = cmd_hdg;
              ff_d      = (cmd_op == OP_MOVE_FF);
              // A zero-square move leaves the timer at zero and exits
              // after one cycle without ever raising moving.
              if (cmd_sq != 4'd0) begin
                moving_d = 1'b1;
                tmr_val  = move_load(cmd_sq, SQ_CYCLES);
              end
            end
            OP_TOUR: begin
              state_d = ST_CAL;
              tour_d  = 1'b1;
            end
            default: begin
              state_d = ST_CAL;
              err_d   = 1'b1;
            end
          endcase
        end
      end

      ST_CAL: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = ST_RESP;
          send_d  = 1'b1;
        end
      end

      ST_MOVE: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = ST_RESP;
          send_d  = 1'b1;
          fan_d   = ff_q;
        end else begin
          moving_d = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset wins from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      heading_q <= 8'h00;
      ff_q      <= 1'b0;
      moving_q  <= 1'b0;
      clr_q     <= 1'b0;
      send_q    <= 1'b0;
      fan_q     <= 1'b0;
      tour_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      ff_q      <= ff_d;
      moving_q  <= moving_d;
      clr_q     <= clr_d;
      send_q    <= send_d;
      fan_q     <= fan_d;
      tour_q    <= tour_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.clr_cmd_rdy = clr_q;
  assign bus.send_resp   = send_q;
  assign bus.heading     = heading_q;
  assign bus.moving      = moving_q;
  assign bus.fanfare     = fan_q;
  assign bus.tour_go     = tour_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_cmd_exec.sv
// Directed bench for cmd_exec with SQ_CYCLES=4, CAL_CYCLES=8. A table of
// commands with hand-computed timing is replayed in order, followed by
// hand-written sequences for held cmd_rdy, reset mid-move and a command
// pending across reset.
module tb_cmd_exec;

  logic clk = 1'b0;
  logic rst;

  cmd_exec_if bus();

  cmd_exec #(
    .SQ_CYCLES  (4),
    .CAL_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Cycle numbers are relative to the accepting edge N (cycle 1 = N+1);
  // -1 means the event was never seen.
  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  hdg;   // heading expected from cycle N+1 on
    int          mv;    // number of moving cycles
    int          send;  // send_resp cycle
    int          ff;    // fanfare expected with send_resp
    int          tour;  // tour_go expected at N+1
    int          err;   // err expected at N+1
  } vec_t;

  vec_t vecs[9];

  function automatic int flags();
    return int'({bus.clr_cmd_rdy, bus.send_resp, bus.moving, bus.fanfare,
                 bus.tour_go, bus.err, bus.busy});
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int clr_n = 0, clr_first = -1;
    int mv_n = 0, mv_first = -1, mv_last = -1;
    int send_c = -1, ff_n = 0, ff_at_send = 0;
    int tour_n = 0, tour_c = -1, err_n = 0, err_c = -1;
    int busy_bad = 0, hdg1 = -1;

    @(negedge clk);
    bus.cmd     = v.cmd;
    bus.cmd_rdy = 1'b1;
    @(posedge clk);  // accepting edge N
    for (int c = 1; c <= 100 && send_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) hdg1 = int'(bus.heading);
      if (bus.clr_cmd_rdy) begin
        clr_n++;
        if (clr_first < 0) clr_first = c;
        bus.cmd_rdy = 1'b0;
      end
      if (bus.moving) begin
        mv_n++;
        if (mv_first < 0) mv_first = c;
        mv_last = c;
      end
      if (bus.fanfare) ff_n++;
      if (bus.tour_go) begin tour_n++; if (tour_c < 0) tour_c = c; end
      if (bus.err)     begin err_n++;  if (err_c < 0)  err_c = c;  end
      if (!bus.busy) busy_bad++;
      if (bus.send_resp) begin
        send_c     = c;
        ff_at_send = int'(bus.fanfare);
      end
    end
    bus.cmd_rdy = 1'b0;

    check({tag, " clr_cycle"},    clr_first, 1);
    check({tag, " clr_count"},    clr_n,     1);
    check({tag, " heading"},      hdg1,      int'(v.hdg));
    check({tag, " moving_count"}, mv_n,      v.mv);
    check({tag, " moving_first"}, mv_first,  (v.mv > 0) ? 1 : -1);
    check({tag, " moving_last"},  mv_last,   (v.mv > 0) ? v.mv : -1);
    check({tag, " send_cycle"},   send_c,    v.send);
    check({tag, " fanfare_cnt"},  ff_n,      v.ff);
    check({tag, " fanfare_at_send"}, ff_at_send, v.ff);
    check({tag, " tour_cycle"},   tour_c,    (v.tour != 0) ? 1 : -1);
    check({tag, " tour_count"},   tour_n,    v.tour);
    check({tag, " err_cycle"},    err_c,     (v.err != 0) ? 1 : -1);
    check({tag, " err_count"},    err_n,     v.err);
    check({tag, " busy_gaps"},    busy_bad,  0);

    // Cycle after RESP: back in IDLE with no outputs active.
    @(negedge clk);
    check({tag, " idle_flags"},   flags(),   0);
    check({tag, " idle_heading"}, int'(bus.heading), int'(v.hdg));
  endtask

  initial begin
    int clr_early, clr_second, send_c;

    //               cmd       hdg    mv  send ff tour err
    vecs[0] = '{16'h23F2, 8'h3F,  8,   9, 0, 0, 0};
    vecs[1] = '{16'h3011, 8'h01,  4,   5, 1, 0, 0};
    vecs[2] = '{16'h0000, 8'h01,  0,   9, 0, 0, 0};
    vecs[3] = '{16'h4000, 8'h01,  0,   2, 0, 1, 0};
    vecs[4] = '{16'h9000, 8'h01,  0,   2, 0, 0, 1};
    vecs[5] = '{16'h2AB0, 8'hAB,  0,   2, 0, 0, 0};
    vecs[6] = '{16'h3000, 8'h00,  0,   2, 1, 0, 0};
    vecs[7] = '{16'h2F5F, 8'hF5, 60,  61, 0, 0, 0};
    vecs[8] = '{16'h1234, 8'hF5,  0,   2, 0, 0, 1};

    rst         = 1'b1;
    bus.cmd     = 16'h0000;
    bus.cmd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset flags",   flags(), 0);
    check("reset heading", int'(bus.heading), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // cmd_rdy held through a whole move: one ack during the move, then the
    // next ack comes from the first IDLE edge after RESP (RESP at 9, IDLE 10,
    // second ack visible at 11).
    clr_early  = 0;
    clr_second = 0;
    send_c     = -1;
    @(negedge clk);
    bus.cmd     = 16'h23F2;
    bus.cmd_rdy = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (bus.clr_cmd_rdy && c <= 10) clr_early++;
      if (bus.clr_cmd_rdy && c == 11) clr_second++;
      if (bus.send_resp && send_c < 0) send_c = c;
    end
    bus.cmd_rdy = 1'b0;
    check("held clr_during_move", clr_early,  1);
    check("held send_cycle",      send_c,     9);
    check("held reaccept_clr",    clr_second, 1);

    // Second move is now under way; reset it part-way through.
    repeat (2) @(negedge clk);
    check("midmove moving", int'(bus.moving), 1);
    check("midmove heading", int'(bus.heading), 8'h3F);
    rst = 1'b1;
    @(negedge clk);
    check("rst_midmove flags",   flags(), 0);
    check("rst_midmove heading", int'(bus.heading), 0);

    // Command pending during reset must wait for the first edge with rst low.
    bus.cmd     = 16'h4000;
    bus.cmd_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("pending_in_rst flags%0d", c), flags(), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst clr",  int'(bus.clr_cmd_rdy), 1);
    check("post_rst tour", int'(bus.tour_go), 1);
    bus.cmd_rdy = 1'b0;
    @(negedge clk);
    check("post_rst send",        int'(bus.send_resp), 1);
    check("post_rst clr_dropped", int'(bus.clr_cmd_rdy), 0);
    @(negedge clk);
    check("post_rst idle", flags(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
